// File: rtl/dbg_pkg.sv
// Shared types and helpers for the pipeline run-control block.
package dbg_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2,
        STEP   = 2'd3
    } run_state_e;

    localparam int unsigned DRAIN_CYC_DEF = 4;

    typedef struct packed {
        logic        valid;
        logic [29:0] addr;
    } bp_entry_t;

    // Index width that stays at least one bit for single-entry configurations.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dbg_bp_table.sv
// PC breakpoint register file with per-entry comparators; the lowest matching index wins.
module dbg_bp_table import dbg_pkg::*; #(
    parameter int unsigned NUM_BP = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_wr_en,
    input  logic [idx_w(NUM_BP)-1:0]    i_wr_idx,
    input  logic [29:0]                 i_wr_addr,
    input  logic                        i_wr_valid,
    input  logic [29:0]                 i_pc,
    output logic                        o_match,
    output logic [idx_w(NUM_BP)-1:0]    o_idx
);

    localparam int unsigned IDX_W = idx_w(NUM_BP);

    bp_entry_t entries [NUM_BP];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < NUM_BP; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_BP; i++) begin
                if (i_wr_en && (i_wr_idx == IDX_W'(i))) begin
                    entries[i] <= '{valid: i_wr_valid, addr: i_wr_addr};
                end
            end
        end
    end

    always_comb begin
        logic found;
        found   = 1'b0;
        o_idx   = '0;
        for (int unsigned i = 0; i < NUM_BP; i++) begin
            if (!found && entries[i].valid && (entries[i].addr == i_pc)) begin
                found = 1'b1;
                o_idx = IDX_W'(i);
            end
        end
        o_match = found;
    end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run-control sequencer: halt, resume, single-step and PC breakpoints for the 5-stage pipeline,
// plus a saturating retired-instruction counter.
module pipeline_run_ctrl import dbg_pkg::*; #(
    parameter int unsigned NUM_BP    = 4,
    parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEF,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_halt_req,
    input  logic                        i_resume_req,
    input  logic                        i_step_req,
    input  logic                        i_bp_wr_en,
    input  logic [idx_w(NUM_BP)-1:0]    i_bp_wr_idx,
    input  logic [31:0]                 i_bp_wr_addr,
    input  logic                        i_bp_wr_valid,
    input  logic [31:0]                 i_pc_f,
    input  logic                        i_stall_f,
    input  logic                        i_insn_vld,
    input  logic                        i_cnt_clr,
    output logic                        o_hold_f,
    output logic                        o_bubble_d,
    output logic                        o_halted,
    output logic [1:0]                  o_state,
    output logic                        o_bp_hit,
    output logic [idx_w(NUM_BP)-1:0]    o_bp_idx,
    output logic                        o_step_done,
    output logic [CNT_W-1:0]            o_retired_cnt
);

    localparam int unsigned IDX_W = idx_w(NUM_BP);
    localparam int unsigned DW    = idx_w(DRAIN_CYC);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYC - 1);

    run_state_e         state, state_nxt;
    logic [DW-1:0]      drain_cnt, drain_cnt_nxt;
    logic               skip, step_pending, bp_hit, step_done;
    logic [IDX_W-1:0]   bp_idx;
    logic [CNT_W-1:0]   retired;

    logic               raw_match, bp_match, trigger, leave_halt, step_accept, drain_done;
    logic [IDX_W-1:0]   raw_idx;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^{i_bp_wr_addr[1:0], i_pc_f[1:0]};

    dbg_bp_table #(
        .NUM_BP (NUM_BP)
    ) u_bp_table (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wr_en    (i_bp_wr_en),
        .i_wr_idx   (i_bp_wr_idx),
        .i_wr_addr  (i_bp_wr_addr[31:2]),
        .i_wr_valid (i_bp_wr_valid),
        .i_pc       (i_pc_f[31:2]),
        .o_match    (raw_match),
        .o_idx      (raw_idx)
    );

    assign bp_match = raw_match && !skip;

    // The trigger cycle already counts as the first drain cycle, so DRAIN exits on the
    // cycle the counter would reach zero and HALTED starts DRAIN_CYC cycles after trigger.
    assign drain_done = (state == DRAIN) && (drain_cnt <= DW'(1));

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        o_hold_f      = 1'b0;
        o_bubble_d    = 1'b0;
        trigger       = 1'b0;
        leave_halt    = 1'b0;
        step_accept   = 1'b0;
        case (state)
            RUN: begin
                trigger = i_halt_req || bp_match;
                if (trigger) begin
                    o_hold_f      = 1'b1;
                    o_bubble_d    = 1'b1;
                    state_nxt     = DRAIN;
                    drain_cnt_nxt = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                o_hold_f   = 1'b1;
                o_bubble_d = 1'b1;
                if (drain_done) begin
                    state_nxt = HALTED;
                end else begin
                    drain_cnt_nxt = drain_cnt - DW'(1);
                end
            end
            HALTED: begin
                o_hold_f   = 1'b1;
                o_bubble_d = 1'b1;
                if (i_step_req) begin
                    state_nxt  = STEP;
                    leave_halt = 1'b1;
                end else if (i_resume_req) begin
                    state_nxt  = RUN;
                    leave_halt = 1'b1;
                end
            end
            STEP: begin
                if (!i_stall_f) begin
                    step_accept   = 1'b1;
                    state_nxt     = DRAIN;
                    drain_cnt_nxt = DRAIN_LOAD;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= RUN;
            drain_cnt    <= '0;
            skip         <= 1'b0;
            step_pending <= 1'b0;
            step_done    <= 1'b0;
            bp_hit       <= 1'b0;
            bp_idx       <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            step_done <= drain_done && step_pending;

            if (step_accept) begin
                step_pending <= 1'b1;
            end else if (drain_done) begin
                step_pending <= 1'b0;
            end

            if (leave_halt) begin
                bp_hit <= 1'b0;
            end else if (trigger && bp_match) begin
                bp_hit <= 1'b1;
                bp_idx <= raw_idx;
            end

            // Skip stays armed until the breakpoint PC has actually been fetched once.
            if (leave_halt) begin
                skip <= 1'b1;
            end else if ((state == RUN) && !i_stall_f) begin
                skip <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            retired <= '0;
        end else if (i_cnt_clr) begin
            retired <= '0;
        end else if (i_insn_vld && (retired != '1)) begin
            retired <= retired + CNT_W'(1);
        end
    end

    assign o_state       = state;
    assign o_halted      = (state == HALTED);
    assign o_bp_hit      = bp_hit;
    assign o_bp_idx      = bp_idx;
    assign o_step_done   = step_done;
    assign o_retired_cnt = retired;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed self-checking bench for pipeline_run_ctrl (NUM_BP=4, DRAIN_CYC=4, CNT_W=4).
module tb_pipeline_run_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_halt_req = 1'b0, i_resume_req = 1'b0, i_step_req = 1'b0;
    logic        i_bp_wr_en = 1'b0, i_bp_wr_valid = 1'b0;
    logic [1:0]  i_bp_wr_idx = '0;
    logic [31:0] i_bp_wr_addr = '0, i_pc_f = '0;
    logic        i_stall_f = 1'b0, i_insn_vld = 1'b0, i_cnt_clr = 1'b0;
    logic        o_hold_f, o_bubble_d, o_halted, o_bp_hit, o_step_done;
    logic [1:0]  o_state, o_bp_idx;
    logic [3:0]  o_retired_cnt;

    int total = 0;
    int bad   = 0;

    pipeline_run_ctrl #(
        .NUM_BP    (4),
        .DRAIN_CYC (4),
        .CNT_W     (4)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_halt_req    (i_halt_req),
        .i_resume_req  (i_resume_req),
        .i_step_req    (i_step_req),
        .i_bp_wr_en    (i_bp_wr_en),
        .i_bp_wr_idx   (i_bp_wr_idx),
        .i_bp_wr_addr  (i_bp_wr_addr),
        .i_bp_wr_valid (i_bp_wr_valid),
        .i_pc_f        (i_pc_f),
        .i_stall_f     (i_stall_f),
        .i_insn_vld    (i_insn_vld),
        .i_cnt_clr     (i_cnt_clr),
        .o_hold_f      (o_hold_f),
        .o_bubble_d    (o_bubble_d),
        .o_halted      (o_halted),
        .o_state       (o_state),
        .o_bp_hit      (o_bp_hit),
        .o_bp_idx      (o_bp_idx),
        .o_step_done   (o_step_done),
        .o_retired_cnt (o_retired_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic bp_write(input logic [1:0] idx, input logic [31:0] addr, input logic v);
        i_bp_wr_en = 1'b1; i_bp_wr_idx = idx; i_bp_wr_addr = addr; i_bp_wr_valid = v;
        cyc();
        i_bp_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        #1;
        total++; if (o_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", o_state); end
        total++; if ({o_hold_f, o_bubble_d, o_halted, o_bp_hit, o_step_done} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {o_hold_f, o_bubble_d, o_halted, o_bp_hit, o_step_done}); end
        total++; if ({o_bp_idx, o_retired_cnt} !== 6'd0) begin bad++; $display("FAIL reset_idx_cnt got=%h exp=0", {o_bp_idx, o_retired_cnt}); end
        cyc(2);
        i_rst = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid_drain();
        i_halt_req = 1'b1;
        #1;
        total++; if (o_hold_f !== 1'b1) begin bad++; $display("FAIL middrain_trigger_hold got=%b exp=1", o_hold_f); end
        cyc();
        i_halt_req = 1'b0;
        cyc(2);
        total++; if (o_state !== 2'd1) begin bad++; $display("FAIL middrain_in_drain got=%0d exp=1", o_state); end
        #2 i_rst = 1'b1;
        #1;
        total++; if (o_state !== 2'd0) begin bad++; $display("FAIL middrain_rst_state got=%0d exp=0", o_state); end
        total++; if ({o_hold_f, o_bubble_d, o_halted, o_bp_hit, o_step_done} !== 5'b0) begin bad++; $display("FAIL middrain_rst_flags got=%b exp=00000", {o_hold_f, o_bubble_d, o_halted, o_bp_hit, o_step_done}); end
        #1 i_rst = 1'b0;
        cyc();
        total++; if (o_state !== 2'd0) begin bad++; $display("FAIL middrain_after_rst got=%0d exp=0", o_state); end
    endtask

    task automatic test_halt_run();
        i_resume_req = 1'b1; i_step_req = 1'b1;
        cyc();
        i_resume_req = 1'b0; i_step_req = 1'b0;
        total++; if (o_state !== 2'd0) begin bad++; $display("FAIL run_ignores_req got=%0d exp=0", o_state); end
        i_halt_req = 1'b1;
        #1;
        total++; if ({o_hold_f, o_bubble_d} !== 2'b11) begin bad++; $display("FAIL halt_same_cycle got=%b exp=11", {o_hold_f, o_bubble_d}); end
        cyc();
        i_halt_req = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            total++; if ({o_state, o_halted, o_hold_f} !== 4'b01_0_1) begin bad++; $display("FAIL halt_drain_k%0d got=%b exp=0101", k, {o_state, o_halted, o_hold_f}); end
            cyc();
        end
        total++; if ({o_state, o_halted, o_hold_f, o_bubble_d} !== 5'b10_1_1_1) begin bad++; $display("FAIL halt_halted got=%b exp=10111", {o_state, o_halted, o_hold_f, o_bubble_d}); end
        total++; if (o_bp_hit !== 1'b0) begin bad++; $display("FAIL halt_no_bp got=%b exp=0", o_bp_hit); end
        i_halt_req = 1'b1;
        cyc();
        i_halt_req = 1'b0;
        total++; if (o_state !== 2'd2) begin bad++; $display("FAIL halted_ignores_halt got=%0d exp=2", o_state); end
        i_resume_req = 1'b1;
        cyc();
        i_resume_req = 1'b0;
        total++; if ({o_state, o_hold_f} !== 3'b00_0) begin bad++; $display("FAIL resume_to_run got=%b exp=000", {o_state, o_hold_f}); end
    endtask

    task automatic test_bp_hit();
        bp_write(2'd1, 32'h0000_0020, 1'b1);
        bp_write(2'd2, 32'h0000_0043, 1'b1);
        i_pc_f = 32'h38; #1;
        total++; if (o_hold_f !== 1'b0) begin bad++; $display("FAIL bp_no_hit_38 got=%b exp=0", o_hold_f); end
        cyc();
        i_pc_f = 32'h3C; #1;
        total++; if (o_hold_f !== 1'b0) begin bad++; $display("FAIL bp_no_hit_3c got=%b exp=0", o_hold_f); end
        cyc();
        i_pc_f = 32'h40; #1;
        total++; if ({o_hold_f, o_bubble_d} !== 2'b11) begin bad++; $display("FAIL bp_hit_hold got=%b exp=11", {o_hold_f, o_bubble_d}); end
        cyc();
        total++; if ({o_bp_hit, o_bp_idx, o_state} !== 5'b1_10_01) begin bad++; $display("FAIL bp_hit_idx got=%b exp=11001", {o_bp_hit, o_bp_idx, o_state}); end
        cyc(3);
        total++; if ({o_halted, o_bp_hit} !== 2'b11) begin bad++; $display("FAIL bp_halted got=%b exp=11", {o_halted, o_bp_hit}); end
    endtask

    task automatic test_resume_bp();
        i_resume_req = 1'b1; i_stall_f = 1'b1;
        cyc();
        i_resume_req = 1'b0;
        #1;
        total++; if ({o_state, o_bp_hit, o_hold_f} !== 4'b00_0_0) begin bad++; $display("FAIL resume_stalled got=%b exp=0000", {o_state, o_bp_hit, o_hold_f}); end
        cyc();
        i_stall_f = 1'b0; #1;
        total++; if (o_hold_f !== 1'b0) begin bad++; $display("FAIL resume_fetch_once got=%b exp=0", o_hold_f); end
        cyc();
        i_pc_f = 32'h44; #1;
        total++; if (o_hold_f !== 1'b0) begin bad++; $display("FAIL resume_pc44 got=%b exp=0", o_hold_f); end
        cyc();
        i_pc_f = 32'h48;
        cyc();
        i_pc_f = 32'h40; #1;
        total++; if (o_hold_f !== 1'b1) begin bad++; $display("FAIL resume_rehit_loop got=%b exp=1", o_hold_f); end
        cyc();
        total++; if ({o_bp_hit, o_bp_idx} !== 3'b1_10) begin bad++; $display("FAIL resume_rehit_idx got=%b exp=110", {o_bp_hit, o_bp_idx}); end
        cyc(3);
        total++; if (o_halted !== 1'b1) begin bad++; $display("FAIL resume_rehalt got=%b exp=1", o_halted); end
    endtask

    task automatic test_single_step();
        i_cnt_clr = 1'b1;
        cyc();
        i_cnt_clr = 1'b0;
        i_step_req = 1'b1; i_stall_f = 1'b1;
        cyc();
        i_step_req = 1'b0;
        total++; if ({o_state, o_hold_f, o_bubble_d, o_bp_hit} !== 5'b11_0_0_0) begin bad++; $display("FAIL step_enter got=%b exp=11000", {o_state, o_hold_f, o_bubble_d, o_bp_hit}); end
        cyc();
        total++; if ({o_state, o_hold_f} !== 3'b11_0) begin bad++; $display("FAIL step_stall2 got=%b exp=110", {o_state, o_hold_f}); end
        cyc();
        i_stall_f = 1'b0; #1;
        total++; if ({o_state, o_hold_f} !== 3'b11_0) begin bad++; $display("FAIL step_accept got=%b exp=110", {o_state, o_hold_f}); end
        cyc();
        i_pc_f = 32'h44;
        total++; if ({o_state, o_hold_f} !== 3'b01_1) begin bad++; $display("FAIL step_drain got=%b exp=011", {o_state, o_hold_f}); end
        i_insn_vld = 1'b1;
        cyc();
        i_insn_vld = 1'b0;
        total++; if (o_step_done !== 1'b0) begin bad++; $display("FAIL step_done_early got=%b exp=0", o_step_done); end
        cyc(2);
        total++; if ({o_step_done, o_halted} !== 2'b11) begin bad++; $display("FAIL step_done_pulse got=%b exp=11", {o_step_done, o_halted}); end
        cyc();
        total++; if (o_step_done !== 1'b0) begin bad++; $display("FAIL step_done_once got=%b exp=0", o_step_done); end
        total++; if (o_retired_cnt !== 4'd1) begin bad++; $display("FAIL step_retired got=%0d exp=1", o_retired_cnt); end
    endtask

    task automatic test_step_resume_same();
        i_step_req = 1'b1; i_resume_req = 1'b1;
        cyc();
        i_step_req = 1'b0; i_resume_req = 1'b0;
        total++; if (o_state !== 2'd3) begin bad++; $display("FAIL step_wins got=%0d exp=3", o_state); end
        cyc();
        total++; if (o_state !== 2'd1) begin bad++; $display("FAIL step_wins_drain got=%0d exp=1", o_state); end
        cyc(3);
        total++; if ({o_state, o_step_done} !== 3'b10_1) begin bad++; $display("FAIL step_wins_done got=%b exp=101", {o_state, o_step_done}); end
    endtask

    task automatic test_bp_table_edges();
        i_resume_req = 1'b1;
        cyc();
        i_resume_req = 1'b0;
        cyc();
        i_pc_f = 32'h90;
        i_bp_wr_en = 1'b1; i_bp_wr_idx = 2'd1; i_bp_wr_addr = 32'h90; i_bp_wr_valid = 1'b1;
        #1;
        total++; if (o_hold_f !== 1'b0) begin bad++; $display("FAIL wr_same_cycle_old got=%b exp=0", o_hold_f); end
        cyc();
        i_bp_wr_en = 1'b0; #1;
        total++; if (o_hold_f !== 1'b1) begin bad++; $display("FAIL wr_next_cycle_new got=%b exp=1", o_hold_f); end
        cyc();
        total++; if ({o_bp_hit, o_bp_idx} !== 3'b1_01) begin bad++; $display("FAIL wr_hit_idx got=%b exp=101", {o_bp_hit, o_bp_idx}); end
        cyc(3);
        bp_write(2'd0, 32'h80, 1'b1);
        bp_write(2'd3, 32'h80, 1'b1);
        i_pc_f = 32'h80; i_resume_req = 1'b1;
        cyc();
        i_resume_req = 1'b0; #1;
        total++; if (o_hold_f !== 1'b0) begin bad++; $display("FAIL dual_skip got=%b exp=0", o_hold_f); end
        cyc();
        total++; if (o_hold_f !== 1'b1) begin bad++; $display("FAIL dual_hold got=%b exp=1", o_hold_f); end
        cyc();
        total++; if ({o_bp_hit, o_bp_idx} !== 3'b1_00) begin bad++; $display("FAIL dual_idx got=%b exp=100", {o_bp_hit, o_bp_idx}); end
        cyc(3);
    endtask

    task automatic test_counter_sat();
        i_cnt_clr = 1'b1;
        cyc();
        i_cnt_clr = 1'b0; i_insn_vld = 1'b1;
        cyc(7);
        total++; if (o_retired_cnt !== 4'd7) begin bad++; $display("FAIL cnt_seven got=%0d exp=7", o_retired_cnt); end
        cyc(13);
        total++; if (o_retired_cnt !== 4'd15) begin bad++; $display("FAIL cnt_saturate got=%0d exp=15", o_retired_cnt); end
        i_cnt_clr = 1'b1;
        cyc();
        i_cnt_clr = 1'b0; i_insn_vld = 1'b0;
        total++; if (o_retired_cnt !== 4'd0) begin bad++; $display("FAIL cnt_clr_priority got=%0d exp=0", o_retired_cnt); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_drain();
        test_halt_run();
        test_bp_hit();
        test_resume_bp();
        test_single_step();
        test_step_resume_same();
        test_bp_table_edges();
        test_counter_sat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
